// File: rtl/rr_arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter.
// Build with RR_ARB_TIMEOUT_EN defined to enable forced revoke of long grants.
package rr_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int REQ_DEF = 8;
    localparam int TMO_DEF = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int tmo);
        return (tmo > 0) ? $clog2(tmo + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the clients and the round-robin arbiter.
// The master side drives requests; the slave side (arbiter) drives grants.
interface rr_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int REQ  = REQ_DEF,
    parameter int REQW = idx_w(REQ)
);
    logic [REQ-1:0]  req;
    logic [REQ-1:0]  grant;
    logic            grant_valid;
    logic [REQW-1:0] grant_id;
    logic            timeout;

    modport master (
        output req,
        input  grant, grant_valid, grant_id, timeout
    );

    modport slave (
        input  req,
        output grant, grant_valid, grant_id, timeout
    );
endinterface

// File: rtl/rr_arbiter_pri_enc.sv
// Active-high priority encoder; the highest set index wins.
// valid is low and idx is zero when no input bit is set.
module pri_enc #(
    parameter int W  = 8,
    parameter int IW = 3
) (
    input  logic [W-1:0]  in,
    output logic [IW-1:0] idx,
    output logic          valid
);
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (in[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant held until release.
// Define RR_ARB_TIMEOUT_EN to revoke grants held for TMO cycles.
module rr_arbiter
    import rr_arb_pkg::*;
#(
    parameter int REQ  = REQ_DEF,
    parameter int REQW = idx_w(REQ),
    parameter int TMO  = TMO_DEF
) (
    input  logic         clk,
    input  logic         reset,
    rr_arbiter_if.slave  bus
);
    if (REQ < 2 || TMO < 1) begin : g_bad_params
        $error("rr_arbiter: REQ must be >= 2 and TMO >= 1");
    end

    function automatic logic [REQ-1:0] below_mask(input logic [REQW-1:0] p);
        return (REQ'(1) << p) - REQ'(1);
    endfunction

    arb_state_t      state, state_nx;
    logic [REQW-1:0] last, last_nx;
    logic [REQW-1:0] gid_q, gid_nx;
    logic            gv_q, gv_nx;
    logic [REQ-1:0]  gnt_q, gnt_nx;

    logic [REQ-1:0]  masked;
    logic [REQW-1:0] m_idx, r_idx, pick;
    logic            m_val, r_val;

    assign masked = bus.req & below_mask(last);

    pri_enc #(.W(REQ), .IW(REQW)) u_enc_mask (
        .in(masked), .idx(m_idx), .valid(m_val)
    );

    pri_enc #(.W(REQ), .IW(REQW)) u_enc_raw (
        .in(bus.req), .idx(r_idx), .valid(r_val)
    );

    // Indices below the last winner go first; otherwise restart at the top.
    assign pick = m_val ? m_idx : r_idx;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = cnt_w(TMO);
    logic [CW-1:0] cnt, cnt_nx;
    logic          tmo_q, tmo_nx;
`endif

    always_comb begin
        state_nx = state;
        last_nx  = last;
        gid_nx   = gid_q;
        gv_nx    = gv_q;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_nx   = cnt;
        tmo_nx   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (r_val) begin
                    state_nx = GRANT;
                    gid_nx   = pick;
                    gv_nx    = 1'b1;
                    last_nx  = pick;
`ifdef RR_ARB_TIMEOUT_EN
                    cnt_nx   = '0;
`endif
                end else begin
                    gid_nx = '0;
                    gv_nx  = 1'b0;
                end
            end
            GRANT: begin
                if (!bus.req[gid_q]) begin
                    state_nx = IDLE;
                    gid_nx   = '0;
                    gv_nx    = 1'b0;
                end
`ifdef RR_ARB_TIMEOUT_EN
                // last keeps the revoked index so it ranks lowest next time
                else if (cnt == CW'(TMO - 1)) begin
                    state_nx = IDLE;
                    gid_nx   = '0;
                    gv_nx    = 1'b0;
                    tmo_nx   = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
        gnt_nx = gv_nx ? (REQ'(1) << gid_nx) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            last  <= '0;
            gid_q <= '0;
            gv_q  <= 1'b0;
            gnt_q <= '0;
        end else begin
            state <= state_nx;
            last  <= last_nx;
            gid_q <= gid_nx;
            gv_q  <= gv_nx;
            gnt_q <= gnt_nx;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt   <= cnt_nx;
            tmo_q <= tmo_nx;
        end
    end

    assign bus.timeout = tmo_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.grant       = gnt_q;
    assign bus.grant_valid = gv_q;
    assign bus.grant_id    = gid_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: directed request vectors with expected grants.
// Define RR_ARB_TIMEOUT_EN to exercise forced revoke with TMO=4.
module tb_rr_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rr_arbiter_if #(.REQ(8)) bus ();

    rr_arbiter #(.REQ(8), .TMO(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        bit       rst;
        bit [7:0] req;
        bit [7:0] g;
        bit [2:0] id;
        bit       tmo;
    } vec_t;

    typedef struct {
        int       due;
        int       row;
        bit [7:0] g;
        bit [2:0] id;
        bit       tmo;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic add(input bit rst, input bit [7:0] req,
                       input bit [7:0] g, input bit [2:0] id,
                       input bit tmo);
        vec_t v;
        v.rst = rst; v.req = req; v.g = g; v.id = id; v.tmo = tmo;
        vecs.push_back(v);
    endtask

    task automatic build();
        bit [7:0] b;
        int id;
        // reset dominates requests
        add(1, 8'hFF, 8'h00, 0, 0);
        add(1, 8'hFF, 8'h00, 0, 0);
        // first grant to highest index, then masked search
        add(0, 8'h81, 8'h80, 7, 0);
        add(0, 8'h81, 8'h80, 7, 0);
        add(0, 8'h81, 8'h80, 7, 0);
        add(0, 8'h01, 8'h00, 0, 0);
        add(0, 8'h01, 8'h01, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        // full rotation 7..0 then wrap to 7
        for (int k = 0; k < 9; k++) begin
            id = (k == 8) ? 7 : 7 - k;
            b  = 8'h01 << id;
            add(0, 8'hFF, b, 3'(id), 0);
            add(0, 8'hFF, b, 3'(id), 0);
            add(0, 8'hFF & ~b, 8'h00, 0, 0);
        end
        add(0, 8'h00, 8'h00, 0, 0);
        // no preemption by a higher requester
        add(0, 8'h10, 8'h10, 4, 0);
        add(0, 8'h10, 8'h10, 4, 0);
        add(0, 8'h50, 8'h10, 4, 0);
        add(0, 8'h50, 8'h10, 4, 0);
        add(0, 8'h40, 8'h00, 0, 0);
        add(0, 8'h40, 8'h40, 6, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        // reset mid-grant returns pointer to 0
        add(0, 8'h10, 8'h10, 4, 0);
        add(0, 8'h10, 8'h10, 4, 0);
        add(1, 8'h10, 8'h00, 0, 0);
        add(0, 8'h12, 8'h10, 4, 0);
        add(0, 8'h12, 8'h10, 4, 0);
        // owner drops while another rises: release first
        add(0, 8'h02, 8'h00, 0, 0);
        add(0, 8'h02, 8'h02, 1, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        // single-cycle pulse
        add(0, 8'h04, 8'h04, 2, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
`ifdef RR_ARB_TIMEOUT_EN
        for (int k = 0; k < 12; k++) begin
            if (k == 4 || k == 9)
                add(0, 8'h08, 8'h00, 0, 1);
            else
                add(0, 8'h08, 8'h08, 3, 0);
        end
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        // release on the expiry edge is not a timeout
        for (int k = 0; k < 4; k++)
            add(0, 8'h08, 8'h08, 3, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
`else
        for (int k = 0; k < 12; k++)
            add(0, 8'h08, 8'h08, 3, 0);
        add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 0, 0);
`endif
    endtask

    initial begin
        exp_t e;
        bus.req = '0;
        build();
        for (int r = 0; r < vecs.size(); r++) begin
            @(posedge clk);
            #1;
            reset   = vecs[r].rst;
            bus.req = vecs[r].req;
            e.due = cyc + 1;
            e.row = r;
            e.g   = vecs[r].g;
            e.id  = vecs[r].id;
            e.tmo = vecs[r].tmo;
            exp_q.push_back(e);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected entries unchecked, required 0",
                     exp_q.size());
            n_bad++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            n_vec++;
            if (e.due != cyc) begin
                $display("FAIL sched row %0d: due %0d seen at %0d", e.row, e.due, cyc);
                n_bad++;
            end
            if (bus.grant !== e.g) begin
                $display("FAIL grant row %0d: got %h want %h", e.row, bus.grant, e.g);
                n_bad++;
            end
            if (bus.grant_id !== e.id) begin
                $display("FAIL grant_id row %0d: got %0d want %0d", e.row, bus.grant_id, e.id);
                n_bad++;
            end
            if (bus.grant_valid !== (e.g != 8'h00)) begin
                $display("FAIL grant_valid row %0d: got %b want %b",
                         e.row, bus.grant_valid, (e.g != 8'h00));
                n_bad++;
            end
            if (bus.timeout !== e.tmo) begin
                $display("FAIL timeout row %0d: got %b want %b", e.row, bus.timeout, e.tmo);
                n_bad++;
            end
        end
    end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among REQ requesters.
- Registered one-hot grant, with the grant held until the owner drops its request.
- Selection is built from two priority-encoder instances:
  - one on the masked request vector;
  - one on the raw request vector.
- Sits in front of shared buses, register-file write ports or functional units that have multiple clients.

Parameters:
- REQ, 8, number of requesters (≥2).
- REQW, $clog2(REQ), width of the grant index.
- TMO, 16, maximum hold cycles per grant (used only with RR_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req  input  REQ  request vector, bit i = requester i, active high.
- grant  output  REQ  one-hot grant, registered.
- grant_valid  output  1  high while any grant is held.
- grant_id  output  REQW  binary index of the current holder; 0 when idle.
- timeout  output  1  one-cycle pulse on forced revoke; tied 0 without the macro.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. Every register clears on the rising clk edge while reset=1.
- Reset values:
  - grant=0, grant_valid=0, grant_id=0, timeout=0;
  - state=IDLE;
  - last (pointer register, REQW bits)=0;
  - hold counter=0.
- Priority rule: highest index wins within a search set.
  - Candidate set 1 = req bits with index strictly below last. If non-empty, choose its highest index.
  - Otherwise, choose the highest index of raw req.
  - Consequence: after reset (last=0), the first grant goes to the highest requesting index.
- IDLE state:
  - If |req at edge t: grant, grant_id and grant_valid are registered at t+1 with the chosen index c; state=GRANT; last←c.
  - Latency: 1 cycle from request to grant.
  - If req=0: remain in IDLE with outputs 0.
- GRANT state:
  - Holds grant stable; no preemption, regardless of other requests.
  - If req[grant_id]=0 at edge t: grant, grant_valid and grant_id clear at t+1; state=IDLE.
  - Consequence: there is exactly one idle bubble cycle between successive grants. Arbitration for the next grant happens in IDLE.
- Requests are sampled only at edges. A single-cycle req pulse seen in IDLE is granted for one cycle, then released on the next edge.
- Pointer wrap: when last=0, candidate set 1 is empty, so search restarts at REQ-1.
- Simultaneous events:
  - Owner drops req while another bit rises in the same cycle: release takes priority; the new bit is arbitrated in the following IDLE cycle.
  - reset with any req: reset wins.
- Reset mid-grant: grant clears at the next edge and the pointer returns to 0. No partial state survives.
- Invariants:
  - grant is zero or one-hot;
  - grant_valid == |grant;
  - grant == (1<<grant_id) whenever grant_valid=1.

Optional Feature:
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter of $clog2(TMO+1) bits resets to 0 on entering GRANT and increments each cycle in GRANT.
  - When the counter reaches TMO-1 with req[grant_id] still high:
    - next edge clears grant and grant_valid, with state=IDLE;
    - timeout=1 for exactly that one cycle;
    - last keeps the revoked index, so the revoked requester gets the lowest priority in the next search.
  - A normal release on the same edge as expiry takes precedence: timeout=0.
- Undefined: no counter is present; timeout is tied 0; grants are held indefinitely.

Decomposition:
- Package rr_arb_pkg:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - localparam helpers for the REQW and counter-width calculations.
- Sub-module pri_enc, ACT=High, instantiated twice:
  - on (req & below_mask(last));
  - on raw req.
  - Its valid output selects between the two results.
- below_mask is a function that generates ((1<<last)-1).

Test Plan (REQ=8, TMO=4 where the macro is used):
1. Reset asserted with req=8'hFF → grant=0, grant_valid=0, grant_id=0, timeout=0 on every cycle while reset=1.
2. req=8'h81 at cycle 1 → cycle 2: grant=8'h80, grant_id=7. Drop req[7] at cycle 4 → cycle 5: grant=0. Cycle 6: grant=8'h01, grant_id=0.
3. req=8'hFF, each owner drops its bit for one cycle after 2 granted cycles then re-raises it → grant_id sequence 7,6,5,4,3,2,1,0,7 (wrap), one bubble between grants.
4. Owner id=4 holding, req[6] rises at cycle 10 → grant stays 8'h10 until req[4] falls (no preemption).
5. Grant held at 8'h10, reset pulsed one cycle → next cycle grant=0. After reset, with req=8'h12 → grant_id=4 (pointer back to 0).
6. RR_ARB_TIMEOUT_EN, req=8'h08 held constantly → grant=8'h08 for 4 cycles, then grant=0 with timeout=1 for one cycle, then regrant id=3 after the bubble. Repeats periodically.
